// File: rtl/bpu_dyn.sv
// Dynamic next-PC predictor: 2-bit counter table for conditional branches plus a
// circular return-address stack for JALR returns; flush redirect always wins.
module bpu_dyn #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     imm,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic            flush_flag,
  input  logic [XLEN-1:0] flush_addr,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            pred_taken,
  output logic [XLEN-1:0] pc_pred
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int BHT_DEPTH = 1 << BHT_IDX_W;
  localparam int PTR_W     = $clog2(RAS_DEPTH);
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  logic [1:0]      bht_r [BHT_DEPTH];
  logic [XLEN-1:0] ras_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] count_r;

  logic [XLEN-1:0]      imm_ext_s;
  logic [XLEN-1:0]      target_s;
  logic [XLEN-1:0]      link_addr_s;
  logic [BHT_IDX_W-1:0] rd_idx_s;
  logic [BHT_IDX_W-1:0] wr_idx_s;
  logic [1:0]           ctr_s;
  logic is_jal_s, is_jalr_s, is_branch_s;
  logic rd_link_s, rs1_link_s;
  logic ret_form_s, pop_s, swap_s, push_s;
  logic ras_en_s, ras_empty_s;

  assign imm_ext_s   = XLEN'($signed(imm));
  assign target_s    = pc + imm_ext_s;
  assign link_addr_s = pc + XLEN'(3'd4);
  assign rd_idx_s    = pc[BHT_IDX_W+1:2];
  assign wr_idx_s    = upd_pc[BHT_IDX_W+1:2];
  assign ctr_s       = bht_r[rd_idx_s];

  assign is_jal_s    = (opcode == OP_JAL);
  assign is_jalr_s   = (opcode == OP_JALR);
  assign is_branch_s = (opcode == OP_BRANCH);
  assign rd_link_s   = is_link(rd);
  assign rs1_link_s  = is_link(rs1);

  // Return form covers plain returns and coroutine swaps; rd == rs1 link is a call only
  assign ret_form_s  = is_jalr_s && rs1_link_s && !(rd_link_s && (rd == rs1));
  assign pop_s       = ret_form_s && !rd_link_s;
  assign swap_s      = ret_form_s && rd_link_s;
  assign push_s      = (is_jal_s || is_jalr_s) && rd_link_s && !swap_s;
  assign ras_en_s    = if_valid && !flush_flag;
  assign ras_empty_s = (count_r == CNT_W'(0));

  // Next-PC selection in fixed priority order
  always_comb begin
    pred_taken = 1'b0;
    pc_pred    = link_addr_s;
    if (flush_flag) begin
      pred_taken = 1'b0;
      pc_pred    = flush_addr;
    end else if (is_jal_s) begin
      pred_taken = 1'b1;
      pc_pred    = target_s;
    end else if (ret_form_s && !ras_empty_s) begin
      pred_taken = 1'b1;
      pc_pred    = ras_r[top_r];
    end else if (is_branch_s && ctr_s[1]) begin
      pred_taken = 1'b1;
      pc_pred    = target_s;
    end else begin
      pred_taken = 1'b0;
      pc_pred    = link_addr_s;
    end
  end

  // Counter training from EX; reset wins over a simultaneous update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken && (bht_r[wr_idx_s] != 2'b11)) begin
        bht_r[wr_idx_s] <= bht_r[wr_idx_s] + 2'b01;
      end else if (!upd_taken && (bht_r[wr_idx_s] != 2'b00)) begin
        bht_r[wr_idx_s] <= bht_r[wr_idx_s] - 2'b01;
      end
    end
  end

  // Circular RAS: pushes overwrite the oldest slot once full, pops on empty are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      top_r   <= PTR_W'(0);
      count_r <= CNT_W'(0);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= XLEN'(0);
      end
    end else if (ras_en_s) begin
      if (swap_s && !ras_empty_s) begin
        ras_r[top_r] <= link_addr_s;
      end else if (push_s || swap_s) begin
        top_r <= top_r + PTR_W'(1);
        ras_r[top_r + PTR_W'(1)] <= link_addr_s;
        if (count_r != CNT_W'(RAS_DEPTH)) begin
          count_r <= count_r + CNT_W'(1);
        end
      end else if (pop_s && !ras_empty_s) begin
        top_r   <= top_r - PTR_W'(1);
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpu_dyn.sv
// Directed bench for bpu_dyn: expected predictions are queued when an instruction is
// presented and compared against the combinational outputs at the following falling edge.
module tb_bpu_dyn;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALU  = 7'b0010011;

  logic            clk;
  logic            rst;
  logic            if_valid;
  logic [XLEN-1:0] pc;
  logic [31:0]     imm;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic            flush_flag;
  logic [XLEN-1:0] flush_addr;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            pred_taken;
  logic [XLEN-1:0] pc_pred;

  int tests = 0;
  int fails = 0;
  logic [XLEN:0] exp_q [$];
  string         tag_q [$];

  bpu_dyn #(.XLEN(32), .BHT_IDX_W(6), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc(pc), .imm(imm), .opcode(opcode),
    .rd(rd), .rs1(rs1), .flush_flag(flush_flag), .flush_addr(flush_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .pred_taken(pred_taken), .pc_pred(pc_pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insn(input logic [6:0] op, input logic [31:0] p, input logic [31:0] im,
                      input logic [4:0] d, input logic [4:0] s);
    opcode = op; pc = p; imm = im; rd = d; rs1 = s;
  endtask

  task automatic expect_pred(input string tag, input logic t, input logic [31:0] a);
    exp_q.push_back({t, a});
    tag_q.push_back(tag);
  endtask

  // Compare every queued expectation against the live outputs, then advance one cycle
  task automatic check_and_step();
    logic [XLEN:0] e;
    logic [XLEN:0] obs;
    string tg;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tg  = tag_q.pop_front();
      obs = {pred_taken, pc_pred};
      tests++;
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed taken=%0b pc=%h, expected taken=%0b pc=%h",
               tg, obs[XLEN], obs[XLEN-1:0], e[XLEN], e[XLEN-1:0]);
      end
    end
    step();
  endtask

  task automatic train(input logic [31:0] a, input logic t, input int n);
    insn(OP_ALU, 32'h0000_0000, 32'h0000_0000, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) begin
      upd_valid = 1'b1; upd_pc = a; upd_taken = t;
      step();
    end
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_valid = 1'b0; flush_flag = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b1; flush_flag = 1'b0; flush_addr = 32'h0000_0000;
    upd_valid = 1'b0; upd_pc = 32'h0000_0000; upd_taken = 1'b0;
    insn(OP_ALU, 32'h0000_0000, 32'h0000_0000, 5'd0, 5'd0);
    step(); step();

    // Outputs during reset follow the priority rules with empty state
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("reset_branch", 1'b0, 32'h0000_0104);
    check_and_step();
    rst = 1'b0;

    // T1 / T2: counter training, no bypass on same-cycle update
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("t1_weak_nt", 1'b0, 32'h0000_0104);
    check_and_step();
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b1;
    expect_pred("no_bypass", 1'b0, 32'h0000_0104);
    check_and_step();
    train(32'h0000_0100, 1'b1, 1);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("t2_taken", 1'b1, 32'h0000_0140);
    check_and_step();
    train(32'h0000_0100, 1'b0, 1);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("one_nt_still_taken", 1'b1, 32'h0000_0140);
    check_and_step();
    train(32'h0000_0100, 1'b0, 1);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("two_nt", 1'b0, 32'h0000_0104);
    check_and_step();
    train(32'h0000_0100, 1'b1, 5);
    train(32'h0000_0100, 1'b0, 1);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("sat_hi", 1'b1, 32'h0000_0140);
    check_and_step();
    train(32'h0000_0100, 1'b0, 5);
    train(32'h0000_0100, 1'b1, 1);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("sat_lo", 1'b0, 32'h0000_0104);
    check_and_step();

    // T3: aliasing and sign-extended immediate
    train(32'h0000_0100, 1'b1, 2);
    insn(OP_BR, 32'h0000_0200, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("t3_alias", 1'b1, 32'h0000_0240);
    check_and_step();
    insn(OP_BR, 32'h0000_0200, 32'hFFFF_FFF0, 5'd0, 5'd0);
    expect_pred("neg_imm", 1'b1, 32'h0000_01F0);
    check_and_step();
    insn(OP_BR, 32'h0000_0104, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("other_idx", 1'b0, 32'h0000_0108);
    check_and_step();
    insn(OP_ALU, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("non_branch", 1'b0, 32'h0000_0104);
    check_and_step();

    // T4: call / return pair, then return on emptied stack
    insn(OP_JAL, 32'h0000_0080, 32'h0000_0020, 5'd1, 5'd0);
    expect_pred("t4_jal", 1'b1, 32'h0000_00A0);
    check_and_step();
    insn(OP_JALR, 32'h0000_00A8, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t4_ret", 1'b1, 32'h0000_0084);
    check_and_step();
    insn(OP_JALR, 32'h0000_00B0, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t4_ret_empty", 1'b0, 32'h0000_00B4);
    check_and_step();

    // T5: five calls overflow a four-deep stack
    do_reset();
    for (int i = 0; i < 5; i++) begin
      insn(OP_JAL, 32'(i * 16), 32'h0000_0100, (i % 2 == 0) ? 5'd1 : 5'd5, 5'd0);
      expect_pred("t5_call", 1'b1, 32'(i * 16 + 256));
      check_and_step();
    end
    insn(OP_JALR, 32'h0000_0200, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t5_ret0", 1'b1, 32'h0000_0044);
    check_and_step();
    insn(OP_JALR, 32'h0000_0210, 32'h0000_0000, 5'd0, 5'd5);
    expect_pred("t5_ret1", 1'b1, 32'h0000_0034);
    check_and_step();
    insn(OP_JALR, 32'h0000_0220, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t5_ret2", 1'b1, 32'h0000_0024);
    check_and_step();
    insn(OP_JALR, 32'h0000_0230, 32'h0000_0000, 5'd2, 5'd5);
    expect_pred("t5_ret3", 1'b1, 32'h0000_0014);
    check_and_step();
    insn(OP_JALR, 32'h0000_0040, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t5_ret4_empty", 1'b0, 32'h0000_0044);
    check_and_step();

    do_reset();
    insn(OP_JALR, 32'h0000_0300, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("empty_after_reset", 1'b0, 32'h0000_0304);
    check_and_step();

    // JALR rd == rs1 == link is a push only; non-link rs1 is never a return
    insn(OP_JALR, 32'h0000_0500, 32'h0000_0000, 5'd1, 5'd1);
    expect_pred("jalr_push_only", 1'b0, 32'h0000_0504);
    check_and_step();
    insn(OP_JALR, 32'h0000_0700, 32'h0000_0000, 5'd0, 5'd2);
    expect_pred("jalr_not_ret", 1'b0, 32'h0000_0704);
    check_and_step();
    insn(OP_JALR, 32'h0000_0600, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("ret_of_push_only", 1'b1, 32'h0000_0504);
    check_and_step();

    // A stalled call must not touch the stack
    if_valid = 1'b0;
    insn(OP_JAL, 32'h0000_0400, 32'h0000_0010, 5'd1, 5'd0);
    expect_pred("stalled_jal", 1'b1, 32'h0000_0410);
    check_and_step();
    if_valid = 1'b1;
    insn(OP_JALR, 32'h0000_0800, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("stalled_no_push", 1'b0, 32'h0000_0804);
    check_and_step();

    // T6: flush wins, RAS frozen, training still happens
    do_reset();
    flush_flag = 1'b1; flush_addr = 32'h0000_2000;
    insn(OP_JAL, 32'h0000_0080, 32'h0000_0020, 5'd1, 5'd0);
    upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b1;
    expect_pred("t6_flush", 1'b0, 32'h0000_2000);
    check_and_step();
    flush_flag = 1'b0; upd_valid = 1'b0;
    insn(OP_JALR, 32'h0000_0900, 32'h0000_0000, 5'd0, 5'd1);
    expect_pred("t6_ras_unchanged", 1'b0, 32'h0000_0904);
    check_and_step();
    train(32'h0000_0100, 1'b1, 0);
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("t6_trained", 1'b1, 32'h0000_0140);
    check_and_step();

    // Reset discards a simultaneous counter update
    rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b1;
    step();
    rst = 1'b0; upd_valid = 1'b0;
    insn(OP_BR, 32'h0000_0100, 32'h0000_0040, 5'd0, 5'd0);
    expect_pred("rst_discards_upd", 1'b0, 32'h0000_0104);
    check_and_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
